uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Two-requester round-robin arbiter in front of a single UART
//                transmitter. Hands one byte at a time to the transmitter,
//                waits for its completion (guarded by a watchdog), then
//                enforces an idle gap before the next byte is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 87,
  parameter int GAP_CLKS     = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Req0_DV,
  input  logic [7:0] i_Req0_Byte,
  output logic       o_Req0_Ack,
  output logic       o_Req0_Done,
  input  logic       i_Req1_DV,
  input  logic [7:0] i_Req1_Byte,
  output logic       o_Req1_Ack,
  output logic       o_Req1_Done,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Busy,
  output logic       o_Grant,
  output logic       o_Timeout
);

  // State encoding
  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_ISSUE     = 2'd1;
  localparam logic [1:0] c_ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] c_ST_GAP       = 2'd3;

  // Watchdog fires on the edge that closes the last allowed WAIT_DONE cycle
  localparam int          c_WD_LIMIT = 12 * CLKS_PER_BIT;
  localparam logic [15:0] c_WD_LAST  = 16'(c_WD_LIMIT - 1);

  // With no gap configured, completion returns straight to IDLE
  localparam bit          c_HAS_GAP  = (GAP_CLKS > 0);
  localparam logic [15:0] c_GAP_LAST = (GAP_CLKS > 0) ? 16'(GAP_CLKS - 1) : 16'd0;

  // State and datapath registers
  logic [1:0]  r_state;
  logic        r_last;       // index of the last requester that finished
  logic [15:0] r_wdog;       // WAIT_DONE cycle count
  logic [15:0] r_gap_cnt;    // GAP cycle count

  // Registered outputs
  logic        r_tx_dv;
  logic [7:0]  r_tx_byte;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_done0;
  logic        r_done1;
  logic        r_busy;
  logic        r_grant;
  logic        r_timeout;

  // Combinational decode
  logic [1:0]  w_next_state;
  logic        w_any_dv;
  logic        w_pick;
  logic        w_capture;
  logic        w_wd_expire;
  logic        w_done_hit;
  logic        w_to_hit;
  logic        w_release;
  logic        w_gap_end;
  logic        w_tx_dv_nxt;
  logic        w_ack0_nxt;
  logic        w_ack1_nxt;
  logic        w_done0_nxt;
  logic        w_done1_nxt;
  logic        w_timeout_nxt;
  logic        w_busy_nxt;

  // Transmitter activity is informational only; it never steers sequencing
  logic        w_unused_tx_active;
  assign w_unused_tx_active = i_Tx_Active;

  // Request selection, completion and watchdog conditions
  always_comb begin
    w_any_dv = i_Req0_DV | i_Req1_DV;
    // On a tie, serve whoever did not finish last; otherwise the lone requester
    if (i_Req0_DV && i_Req1_DV) begin
      w_pick = ~r_last;
    end else begin
      w_pick = i_Req1_DV;
    end
    w_capture   = (r_state == c_ST_IDLE) && w_any_dv;
    w_wd_expire = (r_wdog == c_WD_LAST);
    // A completion in the same cycle as watchdog expiry takes priority
    w_done_hit  = (r_state == c_ST_WAIT_DONE) && i_Tx_Done;
    w_to_hit    = (r_state == c_ST_WAIT_DONE) && !i_Tx_Done && w_wd_expire;
    w_release   = w_done_hit | w_to_hit;
    w_gap_end   = (r_gap_cnt == c_GAP_LAST);
  end

  // State register
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_any_dv) begin
          w_next_state = c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        w_next_state = c_ST_WAIT_DONE;
      end
      c_ST_WAIT_DONE: begin
        if (w_release) begin
          w_next_state = c_HAS_GAP ? c_ST_GAP : c_ST_IDLE;
        end
      end
      c_ST_GAP: begin
        if (w_gap_end) begin
          w_next_state = c_ST_IDLE;
        end
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  // Output decode: values the output registers take at the next edge
  always_comb begin
    w_tx_dv_nxt   = w_capture;
    w_ack0_nxt    = w_capture & ~w_pick;
    w_ack1_nxt    = w_capture &  w_pick;
    w_done0_nxt   = w_done_hit & ~r_grant;
    w_done1_nxt   = w_done_hit &  r_grant;
    w_timeout_nxt = w_to_hit;
    w_busy_nxt    = (w_next_state != c_ST_IDLE);
  end

  // Output registers, captured byte/owner and last-served tracking
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_busy    <= 1'b0;
      r_grant   <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 1'b1;
    end else begin
      r_tx_dv   <= w_tx_dv_nxt;
      r_ack0    <= w_ack0_nxt;
      r_ack1    <= w_ack1_nxt;
      r_done0   <= w_done0_nxt;
      r_done1   <= w_done1_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      // Byte and owner change only when a request is captured
      if (w_capture) begin
        r_tx_byte <= w_pick ? i_Req1_Byte : i_Req0_Byte;
        r_grant   <= w_pick;
      end
      // Ownership is considered finished on either completion or timeout
      if (w_release) begin
        r_last <= r_grant;
      end
    end
  end

  // Watchdog and gap counters, each cleared outside its own state
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wdog    <= 16'd0;
      r_gap_cnt <= 16'd0;
    end else begin
      if (r_state == c_ST_WAIT_DONE) begin
        r_wdog <= r_wdog + 16'd1;
      end else begin
        r_wdog <= 16'd0;
      end
      if (r_state == c_ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + 16'd1;
      end else begin
        r_gap_cnt <= 16'd0;
      end
    end
  end

  assign o_Tx_DV     = r_tx_dv;
  assign o_Tx_Byte   = r_tx_byte;
  assign o_Req0_Ack  = r_ack0;
  assign o_Req1_Ack  = r_ack1;
  assign o_Req0_Done = r_done0;
  assign o_Req1_Done = r_done1;
  assign o_Busy      = r_busy;
  assign o_Grant     = r_grant;
  assign o_Timeout   = r_timeout;

endmodule
`default_nettype wire
